// File: rtl/io_bus_ctrl_pkg.sv
// Register map, FSM encoding and STAT layout shared by the I/O bus controller.
package io_map_pkg;

  localparam logic [31:0] LED_ADDR_DFLT  = 32'h0000_FF00;
  localparam logic [31:0] SW_ADDR_DFLT   = 32'h0000_FF04;
  localparam logic [31:0] STAT_ADDR_DFLT = 32'h0000_FF08;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int STAT_CHG_BIT = 0;
  localparam int STAT_ERR_LSB = 8;

  function automatic logic [15:0] packStat(input logic chg, input logic [7:0] errCnt);
    logic [15:0] s;
    s = '0;
    s[STAT_CHG_BIT] = chg;
    s[STAT_ERR_LSB +: 8] = errCnt;
    return s;
  endfunction

endpackage

// File: rtl/io_bus_ctrl_sw_debounce.sv
// Two-flop synchroniser followed by a per-bus stability counter for the board switches.
module sw_debounce #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int WIDTH        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_stable_o,
  output logic             changed_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q, cand_q, stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q;

  // The counter parks at CNT_MAX, so a long-held value keeps being re-accepted harmlessly.
  always_comb begin
    stable_d = stable_q;
    if (sync2_q == cand_q && cnt_q == CNT_MAX) stable_d = cand_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= sw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign sw_stable_o = stable_q;
  assign changed_o   = (stable_d != stable_q);

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O controller: one CPU access per IDLE->EXEC->RESP pass, owning LED, switch and STAT registers.
module io_bus_ctrl
  import io_map_pkg::*;
#(
  parameter int ADDR_W                   = 32,
  parameter int DATA_W                   = 32,
  parameter logic [ADDR_W-1:0] LED_ADDR  = ADDR_W'(LED_ADDR_DFLT),
  parameter logic [ADDR_W-1:0] SW_ADDR   = ADDR_W'(SW_ADDR_DFLT),
  parameter logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(STAT_ADDR_DFLT),
  parameter int DEBOUNCE_CYC             = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [3:0]        req_be_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  input  logic [15:0]       sw_i,
  output logic [15:0]       led_o
);

  state_e state_q, state_d;
  logic accept, inExec;

  logic              reqWe_q;
  logic [ADDR_W-1:2] reqWordAddr_q;
  logic [15:0]       reqData_q;
  logic [1:0]        reqBe_q;

  logic [DATA_W-1:0] rspRdata_q, rdataExec;
  logic              rspErr_q, accessErr;
  logic              hitLed, hitSw, hitStat, statRead;

  logic [15:0] led_q, swStable;
  logic        swChanged, chg_q;
  logic [7:0]  errCnt_q;

  // Only the low halfword, low byte enables and word address matter to this register map.
  logic unusedReqBits;
  assign unusedReqBits = ^{req_addr_i[1:0], req_wdata_i[DATA_W-1:16], req_be_i[3:2]};

  sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .WIDTH(16)) u_sw_debounce (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sw_i       (sw_i),
    .sw_stable_o(swStable),
    .changed_o  (swChanged)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
    rsp_rdata_o = rspRdata_q;
    rsp_err_o   = rspErr_q;
    led_o       = led_q;
  end

  assign accept = (state_q == IDLE) && req_valid_i;
  assign inExec = (state_q == EXEC);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reqWe_q       <= 1'b0;
      reqWordAddr_q <= '0;
      reqData_q     <= '0;
      reqBe_q       <= '0;
    end else if (accept) begin
      reqWe_q       <= req_we_i;
      reqWordAddr_q <= req_addr_i[ADDR_W-1:2];
      reqData_q     <= req_wdata_i[15:0];
      reqBe_q       <= req_be_i[1:0];
    end
  end

  // Writes to read-only registers are errors, so a STAT read can never also bump ERR_CNT.
  always_comb begin
    hitLed    = (reqWordAddr_q == LED_ADDR[ADDR_W-1:2]);
    hitSw     = (reqWordAddr_q == SW_ADDR[ADDR_W-1:2]);
    hitStat   = (reqWordAddr_q == STAT_ADDR[ADDR_W-1:2]);
    accessErr = !(hitLed || hitSw || hitStat) || (reqWe_q && !hitLed);
    statRead  = hitStat && !reqWe_q;
    rdataExec = '0;
    if (!reqWe_q) begin
      if (hitLed)       rdataExec = DATA_W'(led_q);
      else if (hitSw)   rdataExec = DATA_W'(swStable);
      else if (hitStat) rdataExec = DATA_W'(packStat(chg_q, errCnt_q));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
      led_q      <= '0;
    end else if (inExec) begin
      rspRdata_q <= rdataExec;
      rspErr_q   <= accessErr;
      if (hitLed && reqWe_q) begin
        if (reqBe_q[0]) led_q[7:0]  <= reqData_q[7:0];
        if (reqBe_q[1]) led_q[15:8] <= reqData_q[15:8];
      end
    end
  end

  // A switch change landing on the clearing STAT read keeps CHG set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chg_q    <= 1'b0;
      errCnt_q <= '0;
    end else begin
      if (swChanged)                chg_q <= 1'b1;
      else if (inExec && statRead)  chg_q <= 1'b0;
      if (inExec && accessErr) begin
        if (errCnt_q != 8'hFF) errCnt_q <= errCnt_q + 8'd1;
      end else if (inExec && statRead) begin
        errCnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Scoreboard-driven bench for io_bus_ctrl: LED, debounce, STAT, errors, backpressure and reset abort.
module tb_io_bus_ctrl;

  localparam logic [31:0] LED_A  = 32'h0000_FF00;
  localparam logic [31:0] SW_A   = 32'h0000_FF04;
  localparam logic [31:0] STAT_A = 32'h0000_FF08;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0, reqWe = 1'b0;
  logic [31:0] reqAddr = '0, reqWdata = '0;
  logic [3:0]  reqBe = '0;
  logic        reqReady, rspValid, rspReady = 1'b0, rspErr;
  logic [31:0] rspRdata;
  logic [15:0] sw = '0, led;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbQ[$];
  int checks = 0;
  int passes = 0;

  io_bus_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(reqValid), .req_we_i(reqWe), .req_addr_i(reqAddr),
    .req_wdata_i(reqWdata), .req_be_i(reqBe), .req_ready_o(reqReady),
    .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_rdata_o(rspRdata),
    .rsp_err_o(rspErr), .sw_i(sw), .led_o(led)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Pushes the expected response, performs one full handshake, returns what the DUT answered.
  task automatic runAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] expRdata, input logic expErr,
                           output logic [31:0] gotRdata, output logic gotErr, output int lat);
    int guard;
    sbQ.push_back('{rdata: expRdata, err: expErr});
    guard = 0;
    @(negedge clk);
    while (!reqReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata; reqBe = be;
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rspValid && lat < 20);
    gotRdata = rspRdata;
    gotErr   = rspErr;
    rspReady = 1'b1;
    @(posedge clk);
    #1 rspReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (reqReady !== 1'b1 || rspValid !== 1'b0)
      $display("[TB] FAIL reset_handshake: got ready=%b valid=%b, want ready=1 valid=0", reqReady, rspValid);
    else passes++;
    checks++;
    if (led !== 16'h0 || rspRdata !== 32'h0 || rspErr !== 1'b0)
      $display("[TB] FAIL reset_outputs: got led=%h rdata=%h err=%b, want all 0", led, rspRdata, rspErr);
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_led_write();
    logic [31:0] r; logic e; int lat; exp_t x;
    runAccess(1'b1, LED_A, 32'h0000_A5C3, 4'b0011, 32'h0, 1'b0, r, e, lat);
    x = sbQ.pop_front();
    checks++;
    if (r !== x.rdata || e !== x.err || lat !== 2)
      $display("[TB] FAIL led_write_rsp: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=2", r, e, lat, x.rdata, x.err);
    else passes++;
    checks++;
    if (led !== 16'hA5C3) $display("[TB] FAIL led_write_value: got %h, want a5c3", led);
    else passes++;
  endtask

  task automatic test_partial_led();
    logic [31:0] r; logic e; int lat; exp_t x;
    runAccess(1'b1, LED_A, 32'h0000_FF00, 4'b0010, 32'h0, 1'b0, r, e, lat);
    x = sbQ.pop_front();
    checks++;
    if (r !== x.rdata || e !== x.err || led !== 16'hFFC3)
      $display("[TB] FAIL partial_write: got rdata=%h err=%b led=%h, want rdata=%h err=%b led=ffc3", r, e, led, x.rdata, x.err);
    else passes++;
    runAccess(1'b1, LED_A, 32'hFFFF_FFFF, 4'b1100, 32'h0, 1'b0, r, e, lat);
    x = sbQ.pop_front();
    checks++;
    if (r !== x.rdata || e !== x.err || led !== 16'hFFC3)
      $display("[TB] FAIL upper_be_ignored: got rdata=%h err=%b led=%h, want rdata=%h err=%b led=ffc3", r, e, led, x.rdata, x.err);
    else passes++;
    runAccess(1'b0, LED_A, 32'h0, 4'b0000, 32'h0000_FFC3, 1'b0, r, e, lat);
    x = sbQ.pop_front();
    checks++;
    if (r !== x.rdata || e !== x.err || lat !== 2)
      $display("[TB] FAIL led_readback: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=2", r, e, lat, x.rdata, x.err);
    else passes++;
    runAccess(1'b0, LED_A | 32'h3, 32'h0, 4'b0000, 32'h0000_FFC3, 1'b0, r, e, lat);
    x = sbQ.pop_front();
    checks++;
    if (r !== x.rdata || e !== x.err)
      $display("[TB] FAIL led_read_low_addr_bits: got rdata=%h err=%b, want rdata=%h err=%b", r, e, x.rdata, x.err);
    else passes++;
  endtask

  task automatic test_debounce();
    logic [31:0] r; logic e; int lat; exp_t x;
    logic [31:0] expSeq [4];
    logic [31:0] addrSeq [4];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sw = sw ^ 16'h0001;
      repeat (4) @(negedge clk);
    end
    runAccess(1'b0, SW_A, 32'h0, 4'b0000, 32'h0, 1'b0, r, e, lat);
    x = sbQ.pop_front();
    checks++;
    if (r !== x.rdata || e !== x.err)
      $display("[TB] FAIL sw_bouncing: got rdata=%h err=%b, want rdata=%h err=%b", r, e, x.rdata, x.err);
    else passes++;
    @(negedge clk);
    sw = 16'h0001;
    repeat (25) @(negedge clk);
    addrSeq = '{SW_A, STAT_A, STAT_A, SW_A};
    expSeq  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
    for (int i = 0; i < 4; i++) begin
      runAccess(1'b0, addrSeq[i], 32'h0, 4'b0000, expSeq[i], 1'b0, r, e, lat);
      x = sbQ.pop_front();
      checks++;
      if (r !== x.rdata || e !== x.err)
        $display("[TB] FAIL debounce_read%0d: got rdata=%h err=%b, want rdata=%h err=%b", i, r, e, x.rdata, x.err);
      else passes++;
    end
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int lat; exp_t x; int bad;
    runAccess(1'b0, 32'h0000_1234, 32'h0, 4'b0000, 32'h0, 1'b1, r, e, lat);
    x = sbQ.pop_front();
    checks++;
    if (r !== x.rdata || e !== x.err)
      $display("[TB] FAIL unmapped_read: got rdata=%h err=%b, want rdata=%h err=%b", r, e, x.rdata, x.err);
    else passes++;
    runAccess(1'b1, SW_A, 32'h0000_FFFF, 4'b1111, 32'h0, 1'b1, r, e, lat);
    x = sbQ.pop_front();
    checks++;
    if (r !== x.rdata || e !== x.err)
      $display("[TB] FAIL sw_write: got rdata=%h err=%b, want rdata=%h err=%b", r, e, x.rdata, x.err);
    else passes++;
    runAccess(1'b0, STAT_A, 32'h0, 4'b0000, 32'h0000_0200, 1'b0, r, e, lat);
    x = sbQ.pop_front();
    checks++;
    if (r !== x.rdata || e !== x.err)
      $display("[TB] FAIL stat_err2: got rdata=%h err=%b, want rdata=%h err=%b", r, e, x.rdata, x.err);
    else passes++;
    runAccess(1'b1, 32'h0000_FF10, 32'h0000_1111, 4'b0011, 32'h0, 1'b1, r, e, lat);
    x = sbQ.pop_front();
    checks++;
    if (r !== x.rdata || e !== x.err || led !== 16'hFFC3)
      $display("[TB] FAIL unmapped_write: got rdata=%h err=%b led=%h, want rdata=%h err=%b led=ffc3", r, e, led, x.rdata, x.err);
    else passes++;
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      runAccess(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'h0, 1'b1, r, e, lat);
      x = sbQ.pop_front();
      if (r !== x.rdata || e !== x.err) bad++;
    end
    checks++;
    if (bad !== 0) $display("[TB] FAIL err_burst: got %0d wrong responses of 260, want 0", bad);
    else passes++;
    runAccess(1'b0, STAT_A, 32'h0, 4'b0000, 32'h0000_FF00, 1'b0, r, e, lat);
    x = sbQ.pop_front();
    checks++;
    if (r !== x.rdata || e !== x.err)
      $display("[TB] FAIL stat_saturate: got rdata=%h err=%b, want rdata=%h err=%b", r, e, x.rdata, x.err);
    else passes++;
    runAccess(1'b0, STAT_A, 32'h0, 4'b0000, 32'h0000_0000, 1'b0, r, e, lat);
    x = sbQ.pop_front();
    checks++;
    if (r !== x.rdata || e !== x.err)
      $display("[TB] FAIL stat_cleared: got rdata=%h err=%b, want rdata=%h err=%b", r, e, x.rdata, x.err);
    else passes++;
  endtask

  task automatic test_backpressure();
    exp_t x; int lat;
    sbQ.push_back('{rdata: 32'h0000_FFC3, err: 1'b0});
    @(negedge clk);
    reqValid = 1'b1; reqWe = 1'b0; reqAddr = LED_A; reqWdata = '0; reqBe = '0;
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rspValid && lat < 20);
    x = sbQ.pop_front();
    checks++;
    if (lat !== 2 || rspRdata !== x.rdata || rspErr !== x.err)
      $display("[TB] FAIL stall_first: got lat=%0d rdata=%h err=%b, want lat=2 rdata=%h err=%b", lat, rspRdata, rspErr, x.rdata, x.err);
    else passes++;
    reqValid = 1'b1; reqWe = 1'b1; reqAddr = LED_A; reqWdata = 32'h0; reqBe = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rspValid !== 1'b1 || rspRdata !== x.rdata || rspErr !== x.err || reqReady !== 1'b0)
        $display("[TB] FAIL stall_cycle%0d: got valid=%b rdata=%h err=%b ready=%b, want valid=1 rdata=%h err=%b ready=0",
                 i, rspValid, rspRdata, rspErr, reqReady, x.rdata, x.err);
      else passes++;
    end
    reqValid = 1'b0;
    rspReady = 1'b1;
    @(posedge clk);
    #1 rspReady = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rspValid !== 1'b0 || reqReady !== 1'b1 || led !== 16'hFFC3)
      $display("[TB] FAIL stall_no_accept: got valid=%b ready=%b led=%h, want valid=0 ready=1 led=ffc3", rspValid, reqReady, led);
    else passes++;
  endtask

  task automatic test_reset_exec();
    int seen;
    @(negedge clk);
    reqValid = 1'b1; reqWe = 1'b1; reqAddr = LED_A; reqWdata = 32'h0000_1234; reqBe = 4'b0011;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (reqReady !== 1'b1 || rspValid !== 1'b0 || led !== 16'h0)
      $display("[TB] FAIL reset_exec: got ready=%b valid=%b led=%h, want ready=1 valid=0 led=0", reqReady, rspValid, led);
    else passes++;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rspValid) seen++;
    end
    checks++;
    if (seen !== 0 || led !== 16'h0)
      $display("[TB] FAIL reset_exec_no_rsp: got %0d valid cycles led=%h, want 0 and led=0", seen, led);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_led_write();
    test_partial_led();
    test_debounce();
    test_errors();
    test_backpressure();
    test_reset_exec();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
